// File: rtl/div_ctrl.sv
// div_ctrl: issue/sequencing stage in front of the iterative divider.
// A DIV/DIVU/REM/REMU request is latched on the valid/ready handshake.
// The divider is launched with a one-cycle enable. The controller then
// waits for the divider's ready pulse and returns the tagged result over
// valid/ready.
// A flush while the divider runs drains the divider's (unabortable)
// operation and discards its result. A watchdog recovers from a divider
// that never answers.
// Optional feature: define RESULT_CACHE_EN to keep a one-entry cache of the
// last completed division. An exact repeat is then answered without
// starting the divider. With the macro undefined, every legal request goes
// through the divider.

module div_ctrl #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [XLEN-1:0]  req_rdata1,
  input  logic [XLEN-1:0]  req_rdata2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_enable,
  output logic [3:0]       div_op,
  output logic [XLEN-1:0]  div_rdata1,
  output logic [XLEN-1:0]  div_rdata2,
  input  logic             div_ready,
  input  logic [XLEN-1:0]  div_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Legal ops carry exactly one bit of {remu,rem,divu,divs}.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_enable_q, div_enable_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic             error_q, error_d;

  logic             req_ready_s;
  logic             accept_s;
  logic             timeout_s;
  logic             cache_hit_s;
  logic [XLEN-1:0]  cache_res_s;

  // Requests are only taken while idle and not being flushed; held low during reset.
  assign req_ready_s = (state_q == S_IDLE) && !flush && !rst;
  assign accept_s    = req_valid && req_ready_s;
  // Counter holds the number of cycles already spent waiting on the divider.
  assign timeout_s   = (cnt_q >= CNT_LAST);

`ifdef RESULT_CACHE_EN
  logic            c_valid_q, c_valid_d;
  logic [3:0]      c_op_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_res_q;
  logic            cache_wr_s;

  // Entry is refreshed by every divider result that completes normally.
  assign cache_wr_s  = (state_q == S_BUSY) && !flush && div_ready;
  assign cache_res_s = c_res_q;

  // Lookup: the incoming request must match every stored field.
  always_comb begin
    if (c_valid_q && (req_op == c_op_q) && (req_rdata1 == c_a_q) && (req_rdata2 == c_b_q)) begin
      cache_hit_s = 1'b1;
    end else begin
      cache_hit_s = 1'b0;
    end
  end

  // Entry validity: flush and watchdog expiry drop it; a normal result sets it.
  always_comb begin
    if (flush || error_d) begin
      c_valid_d = 1'b0;
    end else if (cache_wr_s) begin
      c_valid_d = 1'b1;
    end else begin
      c_valid_d = c_valid_q;
    end
  end

  // Cache entry storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_valid_q <= 1'b0;
      c_op_q    <= 4'b0000;
      c_a_q     <= {XLEN{1'b0}};
      c_b_q     <= {XLEN{1'b0}};
      c_res_q   <= {XLEN{1'b0}};
    end else begin
      c_valid_q <= c_valid_d;
      if (cache_wr_s) begin
        c_op_q  <= op_q;
        c_a_q   <= a_q;
        c_b_q   <= b_q;
        c_res_q <= div_result;
      end
    end
  end
`else
  assign cache_hit_s = 1'b0;
  assign cache_res_s = {XLEN{1'b0}};
`endif

  // Next-state, request latches, result capture and watchdog.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d  = req_op;
          a_d   = req_rdata1;
          b_d   = req_rdata2;
          tag_d = req_tag;
          cnt_d = {CNT_W{1'b0}};
          if (!is_onehot(req_op)) begin
            // Malformed op: answer 0 without touching the divider.
            res_d   = {XLEN{1'b0}};
            state_d = S_RESP;
          end else if (cache_hit_s) begin
            res_d   = cache_res_s;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        // The enable is already out this cycle, so a flush must still drain.
        cnt_d = {CNT_W{1'b0}};
        if (flush) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_BUSY;
        end
      end

      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush) begin
          // A result arriving together with the flush needs no drain.
          if (div_ready) begin
            state_d = S_IDLE;
          end else if (timeout_s) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (div_ready) begin
          res_d   = div_result;
          state_d = S_RESP;
        end else if (timeout_s) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_BUSY;
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (div_ready) begin
          state_d = S_IDLE;
        end else if (timeout_s) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      S_RESP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (resp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output flags decoded from the next state so they leave the block registered.
  always_comb begin
    div_enable_d = (state_d == S_ISSUE);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= 4'b0000;
      a_q          <= {XLEN{1'b0}};
      b_q          <= {XLEN{1'b0}};
      tag_q        <= {TAG_W{1'b0}};
      res_q        <= {XLEN{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      div_enable_q <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      div_enable_q <= div_enable_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign req_ready   = req_ready_s;
  assign div_enable  = div_enable_q;
  assign div_op      = op_q;
  assign div_rdata1  = a_q;
  assign div_rdata2  = b_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = res_q;
  assign resp_tag    = tag_q;
  assign busy        = busy_q;
  assign error       = error_q;

endmodule
